// File: rtl/bram_sr_sequencer.sv
// bram_sr_sequencer: walks a 1-cycle-latency BRAM, shifts each word out LSB first.
// Build option SEQ_PARITY_EN appends one even-parity bit after each word.
module bram_sr_sequencer #(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 2,
  parameter int NUM_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_mode,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              word_done,
  output logic              frame_done,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT =
    CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(NUM_WORDS - 1);

`ifdef SEQ_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, RD, WAIT, SHIFT, PAR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD, WAIT, SHIFT
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic              ser_out_d;
  logic              ser_valid_d;
  logic              word_done_d;
  logic              frame_done_d;
  logic              busy_d;
  logic              boundary;
`ifdef SEQ_PARITY_EN
  logic              par_q, par_d;
`endif

  // Next-state and next-output decode; outputs register one cycle behind state.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    addr_d       = bram_addr;
    ser_out_d    = 1'b0;
    ser_valid_d  = 1'b0;
    word_done_d  = 1'b0;
    frame_done_d = 1'b0;
    boundary     = 1'b0;
`ifdef SEQ_PARITY_EN
    par_d        = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD;
          addr_d  = '0;
        end
      end
      RD: begin
        state_d = WAIT;
      end
      WAIT: begin
        shift_d = bram_dout;
        cnt_d   = '0;
`ifdef SEQ_PARITY_EN
        par_d   = ^bram_dout;
`endif
        state_d = SHIFT;
      end
      SHIFT: begin
        ser_out_d   = shift_q[0];
        ser_valid_d = 1'b1;
        shift_d     = shift_q >> 1;
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
`ifdef SEQ_PARITY_EN
          state_d = PAR;
`else
          boundary = 1'b1;
`endif
        end
      end
`ifdef SEQ_PARITY_EN
      PAR: begin
        ser_out_d   = par_q;
        ser_valid_d = 1'b1;
        boundary    = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    if (boundary) begin
      word_done_d = 1'b1;
      if (bram_addr == LAST_ADDR) begin
        frame_done_d = 1'b1;
        if (loop_mode && !stop) begin
          addr_d  = '0;
          state_d = RD;
        end else begin
          state_d = IDLE;
        end
      end else if (stop) begin
        state_d = IDLE;
      end else begin
        addr_d  = bram_addr + ADDR_W'(1);
        state_d = RD;
      end
    end
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      bram_addr  <= '0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      word_done  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
`ifdef SEQ_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      bram_addr  <= addr_d;
      ser_out    <= ser_out_d;
      ser_valid  <= ser_valid_d;
      word_done  <= word_done_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
`ifdef SEQ_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule
